// File: rtl/demux_rr_dispatcher.sv
// Round-robin feeder for the 1-to-8 demux: accepts one item at a time and
// presents it as a one-cycle pulse on D/S to the next non-busy channel.
module demux_rr_dispatcher #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       ch_busy,
    output logic [WIDTH-1:0] D,
    output logic             S2,
    output logic             S1,
    output logic             S0,
    output logic             out_valid,
    output logic             stall,
    output logic [CNT_W-1:0] disp_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DRIVE
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [3:0]       scan;
    logic [2:0]       sel;
    logic [WIDTH-1:0] held;

    assign {S2, S1, S0} = sel;
    assign in_ready     = !rst && (state != HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            scan      <= '0;
            sel       <= '0;
            held      <= '0;
            D         <= '0;
            out_valid <= 1'b0;
            stall     <= 1'b0;
            disp_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    D         <= '0;
                    if (in_valid) begin
                        held  <= in_data;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // A free channel wins over the scan wrap, so stall never
                    // rises on the same cycle as a dispatch.
                    if (!ch_busy[ptr]) begin
                        sel       <= ptr;
                        D         <= held;
                        out_valid <= 1'b1;
                        scan      <= '0;
                        stall     <= 1'b0;
                        state     <= DRIVE;
                    end else begin
                        ptr <= ptr + 3'd1;
                        if (scan == 4'd7) begin
                            stall <= 1'b1;
                            scan  <= '0;
                        end else begin
                            scan <= scan + 4'd1;
                        end
                    end
                end
                DRIVE: begin
                    out_valid <= 1'b0;
                    D         <= '0;
                    ptr       <= ptr + 3'd1;
                    disp_cnt  <= disp_cnt + CNT_W'(1);
                    if (in_valid) begin
                        held  <= in_data;
                        state <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Scoreboard bench for demux_rr_dispatcher: expected channel/data queued at
// acceptance, checked when the one-cycle out_valid pulse appears.
module tb_demux_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] in_data;
    logic [7:0] ch_busy;
    logic [0:0] D;
    logic       S2, S1, S0;
    logic       out_valid;
    logic       stall;
    logic [7:0] disp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] ch;
        logic [0:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] model_ptr = '0;
    logic [7:0] model_cnt = '0;
    logic       prev_ov   = 1'b0;

    demux_rr_dispatcher #(.WIDTH(1), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ch_busy  (ch_busy),
        .D        (D),
        .S2       (S2),
        .S1       (S1),
        .S0       (S0),
        .out_valid(out_valid),
        .stall    (stall),
        .disp_cnt (disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First free channel at or after model_ptr under the mask that will be
    // in force when the item is finally dispatched.
    function automatic logic [2:0] next_free(input logic [7:0] mask);
        logic [2:0] p;
        p = model_ptr;
        for (int i = 0; i < 8; i++) begin
            if (!mask[p]) return p;
            p = p + 3'd1;
        end
        return model_ptr;
    endfunction

    task automatic send(input logic [0:0] d, input logic [7:0] final_mask);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.ch   = next_free(final_mask);
            e.data = d;
            sb_q.push_back(e);
            model_ptr = e.ch + 3'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                chk("pulse_width", prev_ov, 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sel", {S2, S1, S0}, e.ch);
                    chk("data", D, e.data);
                    chk("demux_onehot", D[0] ? (8'd1 << {S2, S1, S0}) : 8'd0,
                        e.data[0] ? (8'd1 << e.ch) : 8'd0);
                    chk("cnt_at_pulse", disp_cnt, model_cnt);
                    chk("stall_at_pulse", stall, 0);
                    model_cnt = model_cnt + 8'd1;
                end
            end else begin
                chk("d_idle_zero", D, 0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ch_busy  = 8'h00;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_D", D, 0);
        chk("idle_S", {S2, S1, S0}, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_stall", stall, 0);
        chk("idle_cnt", disp_cnt, 0);
        chk("idle_in_ready", in_ready, 1);

        // Round robin: first item also checks the two-cycle latency
        send(1'b1, 8'h00);
        @(negedge clk);
        chk("lat_hold", out_valid, 0);
        @(negedge clk);
        chk("lat_drive", out_valid, 1);
        for (int i = 1; i < 8; i++) send(1'b1, 8'h00);
        wait_drain();
        @(negedge clk);
        chk("rr_cnt8", disp_cnt, 8);
        send(1'b0, 8'h00);
        wait_drain();

        // Skip busy channels 1 and 2 starting from ptr 1
        ch_busy = 8'h06;
        send(1'b1, 8'h06);
        send(1'b1, 8'h06);
        wait_drain();
        @(negedge clk);

        // Stall plus handshake hold-off with everything busy
        ch_busy = 8'hFF;
        send(1'b1, 8'hDF);
        in_valid = 1'b1;
        in_data  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("holdoff_ready", in_ready, 0);
            chk("holdoff_cnt", disp_cnt, model_cnt);
            chk("stall_pending", stall, 0);
        end
        @(negedge clk);
        chk("stall_set", stall, 1);
        chk("stall_no_ov", out_valid, 0);
        in_valid = 1'b0;
        ch_busy  = 8'hDF;
        wait_drain();
        @(negedge clk);
        chk("stall_cleared", stall, 0);
        ch_busy = 8'h00;

        // Reset during the DRIVE cycle discards the item
        send(1'b1, 8'h00);
        @(posedge clk);
        #1;
        chk("pre_rst_ov", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_ov", out_valid, 0);
        chk("async_cnt", disp_cnt, 0);
        chk("async_ready", in_ready, 0);
        sb_q.delete();
        model_ptr = '0;
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b1, 8'h00);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("final_cnt", disp_cnt, model_cnt);
        chk("final_q", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Upstream feeder for the 1-to-8 structural demultiplexer. It accepts single data items over a valid/ready handshake and drives them onto the demux data input D. It selects a destination channel round-robin through S2/S1/S0 and skips channels that report busy. Each item is presented for exactly one cycle, with out_valid high, so the downstream demux and channel logic see a clean one-cycle pulse.

Parameters:
WIDTH, 1, data width of in_data and D (the demux data path is 1 bit; wider values are for replicated demux slices)
CNT_W, 8, width of the dispatched-item counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream item available
in_ready  output  1  block can accept an item this cycle
in_data  input  WIDTH  item payload
ch_busy  input  8  per-channel busy flag; bit n high means channel n cannot take an item
D  output  WIDTH  demux data input; 0 unless out_valid
S2  output  1  demux select MSB
S1  output  1  demux select
S0  output  1  demux select LSB
out_valid  output  1  D/S hold a valid item this cycle
stall  output  1  all 8 channels found busy on 8 consecutive checks
disp_cnt  output  CNT_W  number of items dispatched, wraps

Behaviour:
- All outputs except in_ready are registered.
- Reset (asynchronous, active-high, takes effect immediately):
  - D=0, {S2,S1,S0}=0, out_valid=0, stall=0, disp_cnt=0.
  - Internal pointer ptr=0, scan counter=0, state=IDLE.
  - in_ready=0 while rst is high.
- State machine has three states: IDLE, HOLD, DRIVE.
- IDLE:
  - in_ready=1, out_valid=0, D=0.
  - in_valid=1: latch in_data into the holding register and go to HOLD.
- HOLD:
  - in_ready=0.
  - Each cycle, check ch_busy[ptr].
  - If ch_busy[ptr]=0: register {S2,S1,S0}=ptr, D=held data, out_valid=1; clear scan and stall; go to DRIVE.
  - Else: ptr=ptr+1 (7 wraps to 0) and scan=scan+1.
  - When scan reaches 8: stall=1 and scan resets to 0. Searching continues; stall clears on the next successful dispatch.
- DRIVE:
  - out_valid=1 for exactly one cycle; the registered S and D stay stable for that cycle.
  - At the end of the cycle: ptr=ptr+1 (wrap), disp_cnt=disp_cnt+1 (wraps modulo 2^CNT_W).
  - in_ready=1 in DRIVE. If in_valid=1, latch the new item and go to HOLD; otherwise go to IDLE.
  - Next cycle: out_valid=0 and D=0. S keeps its last value.
- Latency: an item accepted in cycle t, with target channel free, gives out_valid=1 in cycle t+2. Sustained throughput is 1 item per 2 cycles.
- ch_busy is sampled only in HOLD; changes in other states are ignored.
- A busy channel is skipped, not waited on. The next item resumes from ptr after the last dispatched channel, not from channel 0.
- If ch_busy[ptr] goes low in the same cycle the scan counter hits 8, the dispatch takes priority and stall stays 0.
- in_valid with in_ready=0 is not accepted. Upstream holds in_valid and in_data until in_ready=1.
- Reset mid-HOLD or mid-DRIVE discards the held item. No out_valid pulse is produced for it.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → D=0, S=000, out_valid=0, stall=0, disp_cnt=0, in_ready=1.
- Round-robin: ch_busy=0x00, 8 items of in_data=1 presented back-to-back → out_valid pulses every 2 cycles with S=000,001,…,111 in order; during each pulse only the demux output matching S is 1; disp_cnt=8; the 9th item goes to S=000.
- Skip busy: ch_busy=0x06 (channels 1,2 busy), ptr=1, one item → dispatched on S=011 one cycle after the first HOLD check plus 2 scan cycles; next item goes to S=100.
- Stall: ch_busy=0xFF, one item → stall=1 after 8 HOLD cycles and out_valid stays 0; then ch_busy=0xDF → dispatch on S=101, stall=0.
- Handshake hold-off: in_valid held high with ch_busy=0xFF → in_ready=0 throughout HOLD, no second item latched, disp_cnt unchanged.
- Reset mid-operation: assert rst in the DRIVE cycle → out_valid drops to 0 immediately (asynchronous), disp_cnt=0, ptr=0; the next item goes to S=000.
